// File: rtl/etc_pkg.sv
// Shared types and default geometry for the ETC2 pixel write path.
package etc_pkg;

    localparam int unsigned IMG_W_DEF       = 128;
    localparam int unsigned IMG_H_DEF       = 128;
    localparam int unsigned ADDR_W_DEF      = 14;
    localparam int unsigned PIX_W_DEF       = 24;
    localparam int unsigned DEC_TIMEOUT_DEF = 64;
    localparam int unsigned BLK_DIM         = 4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_DEC = 3'd1,
        S_WRITE    = 3'd2,
        S_ACK      = 3'd3,
        S_GUARD    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

endpackage

// File: rtl/etc_pix_addr_gen.sv
// Maps a block coordinate plus column-major pixel index within the 4x4 block
// to a linear framebuffer word address (truncated to the address width).
module etc_pix_addr_gen
    import etc_pkg::*;
#(
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [7:0]        block_x,
    input  logic [7:0]        block_y,
    input  logic [3:0]        pix_idx,
    output logic [ADDR_W-1:0] addr
);

    logic [31:0] col;
    logic [31:0] row;

    // Column-major within the block: upper index bits select x, lower select y.
    assign col  = 32'(block_x) * BLK_DIM + 32'(pix_idx[3:2]);
    assign row  = 32'(block_y) * BLK_DIM + 32'(pix_idx[1:0]);
    assign addr = ADDR_W'(row * IMG_W + col);

endmodule

// File: rtl/etc_pixel_write_ctrl.sv
// Per-pixel scheduler between the ETC2 block fetcher, the pixel decoder and the
// framebuffer RAM, with pixel counting and completion/error status.
module etc_pixel_write_ctrl
    import etc_pkg::*;
#(
    parameter int unsigned IMG_W       = IMG_W_DEF,
    parameter int unsigned IMG_H       = IMG_H_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned PIX_W       = PIX_W_DEF,
    parameter int unsigned DEC_TIMEOUT = DEC_TIMEOUT_DEF
) (
    input  logic              sclk,
    input  logic              rsrt_n,
    input  logic              fetch_valid,
    input  logic [7:0]        blockX,
    input  logic [7:0]        blockY,
    input  logic [4:0]        pixIdx,
    input  logic              image_finished,
    output logic              write_finish,
    output logic              dec_start,
    output logic [3:0]        dec_pix,
    input  logic              dec_valid,
    input  logic [PIX_W-1:0]  dec_rgb,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [PIX_W-1:0]  fb_data,
    input  logic              fb_ready,
    output logic [ADDR_W:0]   pix_count,
    output logic              done,
    output logic              err
);

    localparam int unsigned      CNT_W     = ADDR_W + 1;
    localparam int unsigned      TMO_W     = $clog2(DEC_TIMEOUT);
    localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(IMG_W * IMG_H);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(DEC_TIMEOUT - 1);

    state_t             state;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [ADDR_W-1:0]  addr_c;
    logic               pix_hi_unused;

    // Index bit 4 carries no position information inside a 4x4 block.
    assign pix_hi_unused = pixIdx[4];

    etc_pix_addr_gen #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .block_x (blockX),
        .block_y (blockY),
        .pix_idx (pixIdx[3:0]),
        .addr    (addr_c)
    );

    // Sequencer: accept -> decode -> write -> retire -> guard, or terminal DONE.
    always_ff @(posedge sclk) begin
        if (!rsrt_n) begin
            state        <= S_IDLE;
            tmo_cnt      <= '0;
            write_finish <= 1'b0;
            dec_start    <= 1'b0;
            dec_pix      <= '0;
            fb_we        <= 1'b0;
            fb_addr      <= '0;
            fb_data      <= '0;
            pix_count    <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            dec_start    <= 1'b0;
            write_finish <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (image_finished) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        if (pix_count != PIX_TOTAL) begin
                            err <= 1'b1;
                        end
                    end else if (fetch_valid) begin
                        fb_addr   <= addr_c;
                        dec_pix   <= pixIdx[3:0];
                        dec_start <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= S_WAIT_DEC;
                    end
                end
                S_WAIT_DEC: begin
                    // A late decoder still retires the pixel (as zero) so the fetcher never stalls.
                    if (dec_valid) begin
                        fb_data <= dec_rgb;
                        fb_we   <= 1'b1;
                        state   <= S_WRITE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err     <= 1'b1;
                        fb_data <= '0;
                        fb_we   <= 1'b1;
                        state   <= S_WRITE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (fb_ready) begin
                        fb_we        <= 1'b0;
                        write_finish <= 1'b1;
                        if (pix_count != PIX_TOTAL) begin
                            pix_count <= pix_count + 1'b1;
                        end
                        state <= S_ACK;
                    end
                end
                S_ACK:   state <= S_GUARD;
                // The fetcher's valid lags write_finish by a cycle; skip it here.
                S_GUARD: state <= S_IDLE;
                S_DONE:  state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_etc_pixel_write_ctrl.sv
// Randomized bench for etc_pixel_write_ctrl: a 128x128 and an 8x8 instance share
// stimulus and are checked against an arithmetic reference of the pixel schedule.
module tb_etc_pixel_write_ctrl;

    localparam int unsigned BW  = 128;
    localparam int unsigned BH  = 128;
    localparam int unsigned BA  = 14;
    localparam int unsigned SW  = 8;
    localparam int unsigned SH  = 8;
    localparam int unsigned SA  = 6;
    localparam int unsigned PW  = 24;
    localparam int unsigned TMO = 64;

    logic          sclk = 1'b0;
    logic          rsrt_n, fetch_valid, image_finished, dec_valid, fb_ready;
    logic [7:0]    blockX, blockY;
    logic [4:0]    pixIdx;
    logic [PW-1:0] dec_rgb;

    logic          b_write_finish, b_dec_start, b_fb_we, b_done, b_err;
    logic [3:0]    b_dec_pix;
    logic [BA-1:0] b_fb_addr;
    logic [PW-1:0] b_fb_data;
    logic [BA:0]   b_pix_count;

    logic          s_write_finish, s_dec_start, s_fb_we, s_done, s_err;
    logic [3:0]    s_dec_pix;
    logic [SA-1:0] s_fb_addr;
    logic [PW-1:0] s_fb_data;
    logic [SA:0]   s_pix_count;

    int n_vec = 0;
    int n_miss = 0;
    int unsigned exp_cnt_b, exp_cnt_s, exp_starts, exp_retires;
    bit exp_err_b, exp_err_s;
    int unsigned cur_addr_b, cur_addr_s, cur_data;
    int mon_starts = 0;
    int mon_acc = 0;
    int mon_wf = 0;
    int s_hits [SW*SH];
    int s_base [SW*SH];

    always #5 sclk = ~sclk;

    etc_pixel_write_ctrl #(
        .IMG_W(BW), .IMG_H(BH), .ADDR_W(BA), .PIX_W(PW), .DEC_TIMEOUT(TMO)
    ) u_dut (
        .sclk(sclk), .rsrt_n(rsrt_n), .fetch_valid(fetch_valid),
        .blockX(blockX), .blockY(blockY), .pixIdx(pixIdx),
        .image_finished(image_finished), .write_finish(b_write_finish),
        .dec_start(b_dec_start), .dec_pix(b_dec_pix), .dec_valid(dec_valid),
        .dec_rgb(dec_rgb), .fb_we(b_fb_we), .fb_addr(b_fb_addr),
        .fb_data(b_fb_data), .fb_ready(fb_ready), .pix_count(b_pix_count),
        .done(b_done), .err(b_err)
    );

    etc_pixel_write_ctrl #(
        .IMG_W(SW), .IMG_H(SH), .ADDR_W(SA), .PIX_W(PW), .DEC_TIMEOUT(TMO)
    ) u_dut_small (
        .sclk(sclk), .rsrt_n(rsrt_n), .fetch_valid(fetch_valid),
        .blockX(blockX), .blockY(blockY), .pixIdx(pixIdx),
        .image_finished(image_finished), .write_finish(s_write_finish),
        .dec_start(s_dec_start), .dec_pix(s_dec_pix), .dec_valid(dec_valid),
        .dec_rgb(dec_rgb), .fb_we(s_fb_we), .fb_addr(s_fb_addr),
        .fb_data(s_fb_data), .fb_ready(fb_ready), .pix_count(s_pix_count),
        .done(s_done), .err(s_err)
    );

    // Event counters for the one-start / one-write / one-retire accounting.
    always @(posedge sclk) begin
        if (rsrt_n) begin
            if (b_dec_start) mon_starts++;
            if (b_fb_we && fb_ready) mon_acc++;
            if (b_write_finish) mon_wf++;
            if (s_fb_we && fb_ready) s_hits[s_fb_addr]++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned model_addr(input int unsigned bx, input int unsigned by,
                                               input int unsigned pi, input int unsigned w,
                                               input int unsigned aw);
        int unsigned x, y;
        x = bx * 4 + ((pi >> 2) & 3);
        y = by * 4 + (pi & 3);
        return (y * w + x) & ((32'd1 << aw) - 1);
    endfunction

    task automatic scramble();
        fetch_valid = 1'($urandom);
        blockX      = 8'($urandom);
        blockY      = 8'($urandom);
        pixIdx      = 5'($urandom);
        dec_rgb     = 24'($urandom);
    endtask

    task automatic apply_reset(input int cycles, input bit busy);
        rsrt_n = 1'b0; fetch_valid = busy; dec_valid = busy; fb_ready = 1'b0;
        image_finished = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge sclk);
            chk("rst_fb_we", 32'(b_fb_we), 0);
            chk("rst_dec_start", 32'(b_dec_start), 0);
            chk("rst_write_finish", 32'(b_write_finish), 0);
            chk("rst_fb_addr", 32'(b_fb_addr), 0);
            chk("rst_fb_data", 32'(b_fb_data), 0);
            chk("rst_misc", 32'({b_dec_pix, b_pix_count, b_done, b_err}), 0);
            chk("rst_small", 32'({s_fb_we, s_dec_start, s_pix_count, s_done, s_err}), 0);
        end
        exp_cnt_b = 0; exp_cnt_s = 0; exp_err_b = 1'b0; exp_err_s = 1'b0;
    endtask

    // Accept one pixel and run it to the first cycle fb_we is visible.
    task automatic start_pixel(input logic [7:0] bx, input logic [7:0] by, input logic [4:0] pi,
                               input int lat, input logic [23:0] rgb);
        bit tmo;
        bit err_before;
        int nwait;
        tmo        = (lat >= int'(TMO));
        nwait      = tmo ? int'(TMO) - 1 : lat;
        cur_addr_b = model_addr(bx, by, pi, BW, BA);
        cur_addr_s = model_addr(bx, by, pi, SW, SA);
        cur_data   = tmo ? 0 : 32'(rgb);
        err_before = exp_err_b;
        fetch_valid = 1'b1; blockX = bx; blockY = by; pixIdx = pi;
        image_finished = 1'b0; dec_valid = 1'b0;
        @(negedge sclk);
        exp_starts++;
        chk("dec_start", 32'(b_dec_start), 1);
        chk("dec_pix", 32'(b_dec_pix), 32'(pi[3:0]));
        scramble();
        for (int i = 0; i < nwait; i++) begin
            dec_valid = 1'b0;
            @(negedge sclk);
            chk("dec_start_pulse", 32'(b_dec_start), 0);
            chk("fb_we_early", 32'(b_fb_we), 0);
            chk("err_wait", 32'(b_err), 32'(err_before));
            scramble();
        end
        dec_valid = !tmo; dec_rgb = rgb;
        @(negedge sclk);
        if (tmo) begin
            exp_err_b = 1'b1; exp_err_s = 1'b1;
        end
        dec_valid = 1'($urandom); dec_rgb = 24'($urandom);
        chk("fb_we_rise", 32'(b_fb_we), 1);
        chk("fb_addr", 32'(b_fb_addr), cur_addr_b);
        chk("fb_addr_small", 32'(s_fb_addr), cur_addr_s);
        chk("fb_data", 32'(b_fb_data), cur_data);
        chk("err", 32'(b_err), 32'(exp_err_b));
        chk("err_small", 32'(s_err), 32'(exp_err_s));
    endtask

    // Hold off the write for 'stall' cycles, then accept and check retirement.
    task automatic finish_pixel(input int stall);
        for (int s = 0; s < stall; s++) begin
            fb_ready = 1'b0;
            @(negedge sclk);
            chk("bp_fb_we", 32'(b_fb_we), 1);
            chk("bp_fb_addr", 32'(b_fb_addr), cur_addr_b);
            chk("bp_fb_data", 32'(b_fb_data), cur_data);
            chk("bp_write_finish", 32'(b_write_finish), 0);
            scramble();
            dec_valid = 1'($urandom);
        end
        fb_ready = 1'b1;
        @(negedge sclk);
        exp_retires++;
        if (exp_cnt_b < BW * BH) exp_cnt_b++;
        if (exp_cnt_s < SW * SH) exp_cnt_s++;
        chk("write_finish", 32'(b_write_finish), 1);
        chk("fb_we_fall", 32'(b_fb_we), 0);
        chk("pix_count", 32'(b_pix_count), exp_cnt_b);
        chk("pix_count_small", 32'(s_pix_count), exp_cnt_s);
        scramble();
        fetch_valid = 1'b1; dec_valid = 1'($urandom); fb_ready = 1'($urandom);
        @(negedge sclk);
        chk("write_finish_pulse", 32'(b_write_finish), 0);
        chk("ack_ignore", 32'(b_dec_start), 0);
        @(negedge sclk);
        chk("guard_ignore", 32'(b_dec_start), 0);
        fetch_valid = 1'b0; dec_valid = 1'b0; fb_ready = 1'b1;
    endtask

    task automatic do_pixel(input logic [7:0] bx, input logic [7:0] by, input logic [4:0] pi,
                            input int lat, input logic [23:0] rgb, input int stall);
        start_pixel(bx, by, pi, lat, rgb);
        finish_pixel(stall);
    endtask

    initial begin
        exp_starts = 0; exp_retires = 0;
        blockX = '0; blockY = '0; pixIdx = '0; dec_rgb = '0;
        for (int a = 0; a < int'(SW * SH); a++) s_hits[a] = 0;

        // Reset held with a pending pixel, then first pixel accepted right after release.
        apply_reset(3, 1'b1);
        rsrt_n = 1'b1;
        do_pixel(8'd1, 8'd2, 5'd6, 2, 24'hA1B2C3, 0);

        do_pixel(8'd3, 8'd5, 5'd9, 1, 24'h5A5A5A, 4);
        do_pixel(8'd7, 8'd0, 5'd15, 0, 24'h000001, 0);
        // dec_valid on the final timeout cycle still wins.
        do_pixel(8'd31, 8'd31, 5'd0, int'(TMO) - 1, 24'hFEDCBA, 1);

        for (int n = 0; n < 150; n++) begin
            do_pixel(8'($urandom), 8'($urandom), 5'($urandom),
                     ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 12)) : int'($urandom_range(0, 4)),
                     24'($urandom), int'($urandom_range(0, 3)));
        end

        // Decoder never answers: pixel written as zero and err latched.
        do_pixel(8'd2, 8'd9, 5'd4, 1000, 24'hFFFFFF, 0);
        do_pixel(8'd4, 8'd4, 5'd12, 2, 24'h123456, 2);

        // Reset while a write is stalled.
        start_pixel(8'd9, 8'd9, 5'd3, 1, 24'h0F0F0F);
        fb_ready = 1'b0;
        @(negedge sclk);
        chk("stall_fb_we", 32'(b_fb_we), 1);
        apply_reset(1, 1'b0);
        rsrt_n = 1'b1;
        do_pixel(8'd0, 8'd1, 5'd5, 3, 24'hC0FFEE, 1);

        // Whole 8x8 image on the small instance, then end of image.
        apply_reset(2, 1'b0);
        rsrt_n = 1'b1;
        s_base = s_hits;
        for (int by = 0; by < 2; by++)
            for (int bx = 0; bx < 2; bx++)
                for (int p = 0; p < 16; p++)
                    do_pixel(8'(bx), 8'(by), 5'(p), int'($urandom_range(0, 3)),
                             24'($urandom), int'($urandom_range(0, 2)));

        image_finished = 1'b1; fetch_valid = 1'b1;
        @(negedge sclk);
        chk("done_small", 32'(s_done), 1);
        chk("err_small_complete", 32'(s_err), 0);
        chk("done_big", 32'(b_done), 1);
        chk("err_big_incomplete", 32'(b_err), 1);
        chk("done_no_start", 32'(b_dec_start), 0);
        image_finished = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dec_valid = 1'($urandom); fb_ready = 1'($urandom);
            @(negedge sclk);
            chk("done_sticky", 32'(s_done), 1);
            chk("done_quiet", 32'({b_dec_start, b_fb_we, b_write_finish, s_dec_start, s_fb_we}), 0);
        end
        fetch_valid = 1'b0; dec_valid = 1'b0;

        for (int a = 0; a < int'(SW * SH); a++) begin
            chk("addr_written_once", 32'(s_hits[a] - s_base[a]), 1);
        end
        chk("count_dec_start", 32'(mon_starts), exp_starts);
        chk("count_fb_accept", 32'(mon_acc), exp_retires);
        chk("count_write_finish", 32'(mon_wf), exp_retires);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
